// File: rtl/seg7_scan.sv
`default_nettype none
// ============================================================================
// Module      : seg7_scan
// Description : Eight-digit multiplexed seven-segment driver with frame-aligned
//               double buffering, leading-zero blanking and per-digit blink.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_scan #(
  parameter int SCAN_BIT  = 17,
  parameter int BLINK_BIT = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] clkdiv,
  input  logic [31:0] disp_data,
  input  logic [7:0]  point,
  input  logic [7:0]  blink_mask,
  input  logic        lz_en,
  input  logic        load,
  output logic        pending,
  output logic        frame_done,
  output logic [7:0]  AN,
  output logic [7:0]  SEGMENT
);

  logic        r_prev;
  logic [2:0]  r_idx;
  logic        r_pending;
  logic        r_frame_done;
  logic [31:0] r_sh_data;
  logic [7:0]  r_sh_point;
  logic [7:0]  r_sh_mask;
  logic [31:0] r_act_data;
  logic [7:0]  r_act_point;
  logic [7:0]  r_act_mask;
  logic [7:0]  r_an;
  logic [7:0]  r_seg;

  logic        w_tick;
  logic        w_wrap;
  logic [2:0]  w_hi;
  logic [3:0]  w_nib;
  logic        w_blank;
  logic [7:0]  w_an;
  logic [7:0]  w_seg;

  // Segment pattern {g,f,e,d,c,b,a}, active-low.
  function automatic logic [6:0] f_decode(input logic [3:0] nib);
    case (nib)
      4'h0: f_decode = 7'h40;
      4'h1: f_decode = 7'h79;
      4'h2: f_decode = 7'h24;
      4'h3: f_decode = 7'h30;
      4'h4: f_decode = 7'h19;
      4'h5: f_decode = 7'h12;
      4'h6: f_decode = 7'h02;
      4'h7: f_decode = 7'h78;
      4'h8: f_decode = 7'h00;
      4'h9: f_decode = 7'h10;
      4'hA: f_decode = 7'h08;
      4'hB: f_decode = 7'h03;
      4'hC: f_decode = 7'h46;
      4'hD: f_decode = 7'h21;
      4'hE: f_decode = 7'h06;
      default: f_decode = 7'h0E;
    endcase
  endfunction

  assign w_tick = clkdiv[SCAN_BIT] & ~r_prev;
  assign w_wrap = w_tick & (r_idx == 3'd7);

  // Highest nonzero nibble; stays 0 for all-zero data so digit 0 always shows.
  always_comb begin
    w_hi = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (r_act_data[i*4 +: 4] != 4'd0) w_hi = 3'(i);
    end
  end

  always_comb begin
    w_nib   = r_act_data[{r_idx, 2'b00} +: 4];
    w_blank = (lz_en && (r_idx > w_hi)) ||
              (r_act_mask[r_idx] && clkdiv[BLINK_BIT]);
    w_an    = w_blank ? 8'hFF : ~(8'b1 << r_idx);
    w_seg   = w_blank ? 8'hFF : {~r_act_point[r_idx], f_decode(w_nib)};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev       <= 1'b0;
      r_idx        <= 3'd0;
      r_pending    <= 1'b0;
      r_frame_done <= 1'b0;
      r_sh_data    <= 32'd0;
      r_sh_point   <= 8'd0;
      r_sh_mask    <= 8'd0;
      r_act_data   <= 32'd0;
      r_act_point  <= 8'd0;
      r_act_mask   <= 8'd0;
      r_an         <= 8'hFF;
      r_seg        <= 8'hFF;
    end else begin
      r_prev       <= clkdiv[SCAN_BIT];
      r_frame_done <= w_wrap;
      if (w_tick) r_idx <= r_idx + 3'd1;

      // A load landing on the wrap bypasses the shadow so nothing is left pending.
      if (load) begin
        r_sh_data  <= disp_data;
        r_sh_point <= point;
        r_sh_mask  <= blink_mask;
        if (w_wrap) begin
          r_act_data  <= disp_data;
          r_act_point <= point;
          r_act_mask  <= blink_mask;
          r_pending   <= 1'b0;
        end else begin
          r_pending   <= 1'b1;
        end
      end else if (w_wrap && r_pending) begin
        r_act_data  <= r_sh_data;
        r_act_point <= r_sh_point;
        r_act_mask  <= r_sh_mask;
        r_pending   <= 1'b0;
      end

      r_an  <= w_an;
      r_seg <= w_seg;
    end
  end

  assign pending    = r_pending;
  assign frame_done = r_frame_done;
  assign AN         = r_an;
  assign SEGMENT    = r_seg;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg7_scan
// Description : Scoreboard bench for seg7_scan with SCAN_BIT=2, BLINK_BIT=5.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_scan;

  localparam logic [2:0] C_AS = 3'b001;
  localparam logic [2:0] C_P  = 3'b010;
  localparam logic [2:0] C_F  = 3'b100;

  typedef struct {
    int         tag;
    string      nm;
    logic [2:0] chk;
    logic [7:0] an;
    logic [7:0] seg;
    logic       pend;
    logic       fd;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [31:0] clkdiv = 32'd0;
  logic [31:0] disp_data;
  logic [7:0]  point;
  logic [7:0]  blink_mask;
  logic        lz_en;
  logic        load;
  logic        pending;
  logic        frame_done;
  logic [7:0]  AN;
  logic [7:0]  SEGMENT;

  int   tag = -1;
  int   n_total = 0;
  int   n_pass = 0;
  exp_t sb[$];

  seg7_scan #(.SCAN_BIT(2), .BLINK_BIT(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .clkdiv     (clkdiv),
    .disp_data  (disp_data),
    .point      (point),
    .blink_mask (blink_mask),
    .lz_en      (lz_en),
    .load       (load),
    .pending    (pending),
    .frame_done (frame_done),
    .AN         (AN),
    .SEGMENT    (SEGMENT)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // tag = index of the most recent rising edge; clkdiv sampled at edge k equals k.
  always @(posedge clk) begin
    clkdiv <= clkdiv + 32'd1;
    tag    <= tag + 1;
  end

  function automatic void push(int t, string nm, logic [2:0] chk,
                               logic [7:0] an, logic [7:0] seg, logic pend, logic fd);
    exp_t e;
    e.tag = t; e.nm = nm; e.chk = chk;
    e.an = an; e.seg = seg; e.pend = pend; e.fd = fd;
    sb.push_back(e);
  endfunction

  always @(negedge clk) begin : p_mon
    int  i;
    bit  ok;
    i = 0;
    while (i < sb.size()) begin
      if (sb[i].tag == tag) begin
        ok = 1'b1;
        if (sb[i].chk[0] && (AN !== sb[i].an || SEGMENT !== sb[i].seg)) ok = 1'b0;
        if (sb[i].chk[1] && (pending !== sb[i].pend)) ok = 1'b0;
        if (sb[i].chk[2] && (frame_done !== sb[i].fd)) ok = 1'b0;
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s @%0d: got AN=%h SEGMENT=%h pending=%b frame_done=%b, want AN=%h SEGMENT=%h pending=%b frame_done=%b (chk=%b)",
                      sb[i].nm, tag, AN, SEGMENT, pending, frame_done,
                      sb[i].an, sb[i].seg, sb[i].pend, sb[i].fd, sb[i].chk);
        sb.delete(i);
      end else if (sb[i].tag < tag) begin
        n_total++;
        $display("FAIL %s @%0d: sample slot missed, want tag %0d", sb[i].nm, tag, sb[i].tag);
        sb.delete(i);
      end else begin
        i++;
      end
    end
  end

  // Returns #1 after rising edge t.
  task automatic wait_tag(int t);
    int guard;
    guard = 0;
    while (tag < t) begin
      @(posedge clk);
      #1;
      guard++;
      if (guard > 20000) begin
        $display("FAIL wait_tag: timeout waiting for edge %0d", t);
        $fatal(1, "timeout");
      end
    end
  endtask

  // Presents load so the DUT samples it at rising edge t.
  task automatic load_at(int t, logic [31:0] d, logic [7:0] p, logic [7:0] m);
    wait_tag(t - 1);
    disp_data  = d;
    point      = p;
    blink_mask = m;
    load       = 1'b1;
    wait_tag(t);
    load       = 1'b0;
  endtask

  logic [7:0] seg_tbl [8];
  logic [7:0] lz_an   [8];
  logic [7:0] lz_seg  [8];

  initial begin
    rst = 1'b1; load = 1'b0; lz_en = 1'b0;
    disp_data = 32'd0; point = 8'd0; blink_mask = 8'd0;
    seg_tbl = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8};
    lz_an   = '{8'hFE, 8'hFD, 8'hFB, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    lz_seg  = '{8'h92, 8'hC0, 8'h88, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};

    // Reset, then first sample after release (before any further edge).
    push(0, "reset0", C_AS | C_P | C_F, 8'hFF, 8'hFF, 1'b0, 1'b0);
    push(1, "reset1", C_AS | C_P | C_F, 8'hFF, 8'hFF, 1'b0, 1'b0);
    push(2, "post_reset", C_AS | C_P | C_F, 8'hFF, 8'hFF, 1'b0, 1'b0);
    wait_tag(2);
    rst = 1'b0;

    // First wrap is at edge 60; frames then repeat every 64 edges.
    push(59, "fd_before_wrap", C_F, 8'h00, 8'h00, 1'b0, 1'b0);
    push(60, "load_on_wrap", C_P | C_F, 8'h00, 8'h00, 1'b0, 1'b1);
    push(61, "fd_one_cycle", C_F, 8'h00, 8'h00, 1'b0, 1'b0);
    for (int d = 0; d < 8; d++)
      push(64 + 8*d, $sformatf("scan_d%0d", d), C_AS, ~(8'b1 << d), seg_tbl[d], 1'b0, 1'b0);
    load_at(60, 32'h76543210, 8'h00, 8'h00);

    push(90,  "pend_set", C_P, 8'h00, 8'h00, 1'b1, 1'b0);
    push(96,  "old_data_held", C_AS | C_P, 8'hEF, 8'h99, 1'b1, 1'b0);
    push(124, "commit_wrap", C_P | C_F, 8'h00, 8'h00, 1'b0, 1'b1);
    push(125, "fd_drop", C_F, 8'h00, 8'h00, 1'b0, 1'b0);
    push(128, "new_d0", C_AS | C_P, 8'hFE, 8'hF9, 1'b0, 1'b0);
    push(136, "new_d1", C_AS, 8'hFD, 8'hC0, 1'b0, 1'b0);
    load_at(90, 32'h00000001, 8'h00, 8'h00);

    push(150, "pend_two_loads", C_P, 8'h00, 8'h00, 1'b1, 1'b0);
    push(192, "newest_wins", C_AS, 8'hFE, 8'h92, 1'b0, 1'b0);
    load_at(140, 32'h0000000A, 8'h00, 8'h00);
    load_at(150, 32'h00000005, 8'h00, 8'h00);

    for (int d = 0; d < 8; d++)
      push(256 + 8*d, $sformatf("lz_d%0d", d), C_AS, lz_an[d], lz_seg[d], 1'b0, 1'b0);
    wait_tag(199);
    lz_en = 1'b1;
    load_at(200, 32'h00000A05, 8'h00, 8'h00);

    push(320, "zero_d0", C_AS, 8'hFE, 8'hC0, 1'b0, 1'b0);
    push(328, "zero_d1", C_AS, 8'hFF, 8'hFF, 1'b0, 1'b0);
    push(376, "zero_d7", C_AS, 8'hFF, 8'hFF, 1'b0, 1'b0);
    load_at(260, 32'h00000000, 8'h00, 8'h00);

    push(382, "blink_dark", C_AS, 8'hFF, 8'hFF, 1'b0, 1'b0);
    push(384, "blink_lit", C_AS, 8'hFE, 8'hC0, 1'b0, 1'b0);
    push(392, "point_d1", C_AS, 8'hFD, 8'h79, 1'b0, 1'b0);
    push(400, "no_point_d2", C_AS, 8'hFB, 8'hA4, 1'b0, 1'b0);
    load_at(330, 32'h76543210, 8'h02, 8'h01);
    wait_tag(377);
    lz_en = 1'b0;

    push(420, "pend_before_simul", C_P, 8'h00, 8'h00, 1'b1, 1'b0);
    push(444, "simul_wrap", C_P | C_F, 8'h00, 8'h00, 1'b0, 1'b1);
    push(448, "simul_d0", C_AS | C_P, 8'hFE, 8'hC6, 1'b0, 1'b0);
    push(456, "simul_d1", C_AS, 8'hFD, 8'hC0, 1'b0, 1'b0);
    load_at(400, 32'h11111111, 8'h00, 8'h00);
    load_at(444, 32'h0000000C, 8'h00, 8'h00);

    wait_tag(462);
    if (sb.size() != 0) begin
      n_total++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seg7_scan.md
# seg7_scan

Eight-digit multiplexed seven-segment display driver that consumes the free-running `clkdiv` bus from the clock divider. It scans the eight digits using one selected `clkdiv` bit as the scan rate and blinks digits using a second bit. Display data is double-buffered, so a new value only takes effect at a frame boundary and the display never tears. It sits between the CPU/IO data path and the board's anode/segment pins.

## Interface
- `SCAN_BIT`, 17, index of the `clkdiv` bit whose rising edge advances the scan; legal range 0..30.
- `BLINK_BIT`, 24, index of the `clkdiv` bit used as the blink phase; legal range 0..31.
- `clk`  in  1  system clock; the same clock that drives the divider.
- `rst`  in  1  asynchronous, active-high reset.
- `clkdiv`  in  32  free-running divider count, synchronous to `clk`.
- `disp_data`  in  32  eight hex nibbles; nibble *i* is shown on digit *i*.
- `point`  in  8  per-digit decimal point enable; 1 = on.
- `blink_mask`  in  8  per-digit blink enable.
- `lz_en`  in  1  leading-zero blanking enable; sampled live, not buffered.
- `load`  in  1  single-cycle request to capture `disp_data`, `point` and `blink_mask`.
- `pending`  out  1  a captured value is waiting for the next frame boundary.
- `frame_done`  out  1  one-cycle pulse when the scan wraps from digit 7 to digit 0.
- `AN`  out  8  digit enables, active-low, registered.
- `SEGMENT`  out  8  segments `{dp,g,f,e,d,c,b,a}`, active-low, registered.

## Operation
- **Scan tick:** `prev` holds the value of `clkdiv[SCAN_BIT]` from the previous cycle. `tick = clkdiv[SCAN_BIT] & ~prev`.
- **Digit index:** `idx` is 3 bits. On `tick`, `idx` advances by 1 modulo 8.
- **Wrap:** `wrap = tick & (idx == 7)`. On `wrap`, `frame_done` goes to 1 for exactly one cycle.
- **Buffering:** there is a shadow register set {data, point, mask} and an active register set. Only the active set is displayed.
  - `load` without `wrap`: shadow is written with the inputs and `pending` is set to 1. A later `load` before the boundary overwrites the shadow; the newest value wins.
  - `wrap` with `pending` = 1 and no `load`: shadow is copied to active and `pending` is cleared.
  - `load` and `wrap` in the same cycle: the inputs are written to both shadow and active, and `pending` ends at 0.
- **Leading-zero blanking:** let *h* be the index of the highest nonzero nibble of the active data, with *h* = 0 if all nibbles are zero. When `lz_en` = 1, digits with index greater than *h* are blanked. Digit 0 is never blanked by this rule.
- **Blinking:** the current digit is blanked when `blink_mask_active[idx]` = 1 and `clkdiv[BLINK_BIT]` = 1.
- **Blanked digit:** `AN` = 8'hFF and `SEGMENT` = 8'hFF.
- **Shown digit:** `AN` = ~(8'b1 << idx).
  - `SEGMENT[6:0]` is the decoded nibble: 0:C0, 1:F9, 2:A4, 3:B0, 4:99, 5:92, 6:82, 7:F8, 8:80, 9:90, A:88, b:83, C:C6, d:A1, E:86, F:8E. Values are the full byte with dp off.
  - `SEGMENT[7]` = ~`point_active[idx]`.

## Timing
- **Reset values:** `idx` = 0, `prev` = 0, shadow = 0, active = 0, `pending` = 0, `frame_done` = 0, `AN` = 8'hFF, `SEGMENT` = 8'hFF.
- **Tick detection:** `idx` changes on the `clk` edge at which `clkdiv[SCAN_BIT]` is first sampled as 1. `AN`/`SEGMENT` reflect the new `idx` one cycle later.
- **Live inputs:** a change on `clkdiv[BLINK_BIT]` or `lz_en` reaches `AN`/`SEGMENT` after one cycle.
- **Frame boundary:** data committed at `wrap` is first displayed on digit 0 one cycle after the wrap edge. `frame_done` rises on the same edge as the commit.
- **Reset mid-frame:** the shadow is discarded, `pending` clears, and the scan restarts at digit 0.
- **Frame period:** one frame = 8 × 2^(`SCAN_BIT`+1) cycles when `clkdiv` is free-running.

## Test plan
- **Reset:** assert `rst` for 3 cycles with `clkdiv` running -> `AN` = FF, `SEGMENT` = FF and `pending` = 0 during reset and in the first cycle after release.
- **Scan order and decode:** `SCAN_BIT` = 2; load 32'h76543210 coincident with a wrap -> `AN` steps FE, FD, …, 7F with `SEGMENT` C0, F9, A4, B0, 99, 92, 82, F8. `frame_done` pulses once per 64 cycles.
- **Buffering:** load 32'h00000001 mid-frame -> `pending` = 1; digit 0 keeps its old value until `frame_done`; the next digit-0 slot shows F9 and `pending` = 0.
  - Two loads before the boundary -> only the second value is ever displayed.
- **Leading-zero blanking:** `lz_en` = 1, data 32'h00000A05 -> digits 3..7 have `AN` = FF; digit 2 shows 88, digit 1 C0, digit 0 92.
  - Data 0 -> only digit 0 is shown, with C0.
- **Blink and point:** `blink_mask` = 8'h01, `point` = 8'h02, `BLINK_BIT` = 5 -> digit 0 is dark while `clkdiv[5]` = 1; digit 1's `SEGMENT[7]` = 0.
- **Simultaneous load and wrap:** drive `load` exactly in the wrap cycle -> the new data shows on digit 0 in the next slot and `pending` stays 0.
